// File: rtl/fb_port_arbiter.sv
// Frame-buffer port-A arbiter: shares one memory port between CPU accesses and a
// full-buffer fill engine, with round-robin under contention and registered strobes.
module fb_port_arbiter #(
  parameter int unsigned DEPTH  = 2304,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // CPU requester
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  // Fill engine
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_data,
  output logic              fill_busy,
  output logic              fill_done,
  // Memory port A
  output logic [ADDR_W-1:0] addr_a,
  output logic [DATA_W-1:0] data_in_a,
  output logic              wr_en,
  output logic              rd_en,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] fill_word_q, fill_word_d;
  logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
  logic              rr_cpu_q, rr_cpu_d;

  logic              fill_pending;
  logic              cpu_grant;
  logic              fill_grant;
  logic              cpu_in_range;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic              ack_q;

  // Read return pipeline: stage 1 aligns with rd_en, stage 2 with mem_rdata.
  logic              rd_pend_q;
  logic              rd_oor_q;
  logic              rvalid_q;
  logic              rvalid_zero_q;
  logic [DATA_W-1:0] rdata_hold_q;

  assign fill_pending = (state_q == StFill);
  assign cpu_in_range = (32'(cpu_addr) < DEPTH);

  // Arbitration; rr_cpu_q = 1 means the CPU wins the next contended cycle.
  always_comb begin
    cpu_grant  = 1'b0;
    fill_grant = 1'b0;
    rr_cpu_d   = rr_cpu_q;
    if (cpu_req && fill_pending) begin
      cpu_grant  = rr_cpu_q;
      fill_grant = !rr_cpu_q;
      rr_cpu_d   = !rr_cpu_q;
    end else begin
      cpu_grant  = cpu_req;
      fill_grant = fill_pending;
    end
  end

  always_comb begin
    state_d     = state_q;
    fill_word_d = fill_word_q;
    fill_cnt_d  = fill_cnt_q;
    case (state_q)
      StIdle: begin
        if (fill_start) begin
          state_d     = StFill;
          fill_word_d = fill_data;
          fill_cnt_d  = '0;
        end
      end
      StFill: begin
        if (fill_grant) begin
          if (fill_cnt_q == LastAddr) begin
            state_d = StDone;
          end else begin
            fill_cnt_d = fill_cnt_q + ADDR_W'(1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next port-A drive; address/data hold when no strobe is issued.
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    wr_d   = 1'b0;
    rd_d   = 1'b0;
    if (fill_grant) begin
      addr_d = fill_cnt_q;
      data_d = fill_word_q;
      wr_d   = 1'b1;
    end else if (cpu_grant && cpu_in_range) begin
      addr_d = cpu_addr;
      if (cpu_we) begin
        data_d = cpu_wdata;
      end
      wr_d   = cpu_we;
      rd_d   = !cpu_we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      fill_word_q   <= '0;
      fill_cnt_q    <= '0;
      rr_cpu_q      <= 1'b1;
      addr_q        <= '0;
      data_q        <= '0;
      wr_q          <= 1'b0;
      rd_q          <= 1'b0;
      ack_q         <= 1'b0;
      rd_pend_q     <= 1'b0;
      rd_oor_q      <= 1'b0;
      rvalid_q      <= 1'b0;
      rvalid_zero_q <= 1'b0;
      rdata_hold_q  <= '0;
    end else begin
      state_q       <= state_d;
      fill_word_q   <= fill_word_d;
      fill_cnt_q    <= fill_cnt_d;
      rr_cpu_q      <= rr_cpu_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      ack_q         <= cpu_grant;
      rd_pend_q     <= cpu_grant && !cpu_we;
      rd_oor_q      <= !cpu_in_range;
      rvalid_q      <= rd_pend_q;
      rvalid_zero_q <= rd_oor_q;
      rdata_hold_q  <= cpu_rdata;
    end
  end

  // Read data is forwarded straight from the memory in its valid cycle, then held.
  always_comb begin
    cpu_rdata = rdata_hold_q;
    if (rvalid_q) begin
      cpu_rdata = rvalid_zero_q ? '0 : mem_rdata;
    end
  end

  assign cpu_ack    = ack_q;
  assign cpu_rvalid = rvalid_q;
  assign fill_busy  = (state_q == StFill);
  assign fill_done  = (state_q == StDone);
  assign addr_a     = addr_q;
  assign data_in_a  = data_q;
  assign wr_en      = wr_q;
  assign rd_en      = rd_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter: reset, fills, CPU access, contention,
// out-of-range access, ignored restart and reset abort, against a memory model.
module tb_fb_port_arbiter;

  localparam int unsigned DEPTH  = 2304;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  logic              fill_start;
  logic [DATA_W-1:0] fill_data;
  logic              fill_busy;
  logic              fill_done;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] data_in_a;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] mem_rdata;

  int vectors;
  int miscompares;

  fb_port_arbiter #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .cpu_rvalid(cpu_rvalid),
    .fill_start(fill_start),
    .fill_data (fill_data),
    .fill_busy (fill_busy),
    .fill_done (fill_done),
    .addr_a    (addr_a),
    .data_in_a (data_in_a),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  always @(posedge clk) begin
    if (wr_en && (32'(addr_a) < DEPTH)) mem[addr_a] <= data_in_a;
    if (rd_en) mem_rdata <= (32'(addr_a) < DEPTH) ? mem[addr_a] : '0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  int writes, bad, busy_cnt, done_cnt, both_cnt, rd_cnt, alt_bad;
  logic [ADDR_W-1:0] next_addr;
  logic pulsed, found;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst        = 1'b1;
    cpu_req    = 1'b0;
    cpu_we     = 1'b0;
    cpu_addr   = '0;
    cpu_wdata  = '0;
    fill_start = 1'b0;
    fill_data  = '0;
    repeat (3) step();

    // Reset state
    check("rst_ack", 32'(cpu_ack), 32'd0);
    check("rst_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_busy", 32'(fill_busy), 32'd0);
    check("rst_done", 32'(fill_done), 32'd0);
    check("rst_addr", 32'(addr_a), 32'd0);
    check("rst_wdata", data_in_a, 32'd0);
    check("rst_strobes", {30'd0, wr_en, rd_en}, 32'd0);
    rst = 1'b0;
    step();

    // Test 1: plain fill
    fill_start = 1'b1;
    fill_data  = 32'h0F000F00;
    step();
    fill_start = 1'b0;
    fill_data  = 32'hBAD0BAD0;
    writes = 0; bad = 0; busy_cnt = 0; done_cnt = 0; both_cnt = 0; rd_cnt = 0;
    next_addr = '0;
    for (int j = 1; j <= 2310; j++) begin
      if (fill_busy) busy_cnt++;
      if (fill_done) done_cnt++;
      if (wr_en && rd_en) both_cnt++;
      if (rd_en) rd_cnt++;
      if (wr_en) begin
        if (addr_a !== next_addr || data_in_a !== 32'h0F000F00) bad++;
        next_addr = next_addr + 12'd1;
        writes++;
      end
      step();
    end
    check("t1_writes", writes, 2304);
    check("t1_seq_bad", bad, 0);
    check("t1_busy_cycles", busy_cnt, 2304);
    check("t1_done_pulses", done_cnt, 1);
    check("t1_rd_en", rd_cnt, 0);
    check("t1_both", both_cnt, 0);
    check("t1_idle", {30'd0, fill_busy, fill_done}, 32'd0);
    check("t1_mem_last", mem[2303], 32'h0F000F00);

    // Test 2: CPU write then read
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h010; cpu_wdata = 32'hDEADBEEF;
    step();
    check("t2_w_ack", 32'(cpu_ack), 32'd1);
    check("t2_w_wr", {30'd0, wr_en, rd_en}, 32'd2);
    check("t2_w_addr", 32'(addr_a), 32'h010);
    check("t2_w_data", data_in_a, 32'hDEADBEEF);
    cpu_req = 1'b0;
    step();
    check("t2_w_ack_end", 32'(cpu_ack), 32'd0);
    check("t2_w_idle", {30'd0, wr_en, rd_en}, 32'd0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010;
    step();
    check("t2_r_ack", 32'(cpu_ack), 32'd1);
    check("t2_r_rd", {30'd0, wr_en, rd_en}, 32'd1);
    check("t2_r_addr", 32'(addr_a), 32'h010);
    check("t2_r_early", 32'(cpu_rvalid), 32'd0);
    cpu_req = 1'b0;
    step();
    check("t2_rvalid", 32'(cpu_rvalid), 32'd1);
    check("t2_rdata", cpu_rdata, 32'hDEADBEEF);
    step();
    check("t2_rvalid_end", 32'(cpu_rvalid), 32'd0);
    check("t2_rdata_hold", cpu_rdata, 32'hDEADBEEF);

    // Test 4: out-of-range read and write
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h900;
    step();
    check("t4_ack", 32'(cpu_ack), 32'd1);
    check("t4_strobes", {30'd0, wr_en, rd_en}, 32'd0);
    cpu_we = 1'b1; cpu_wdata = 32'h11112222;
    step();
    check("t4_rvalid", 32'(cpu_rvalid), 32'd1);
    check("t4_rdata", cpu_rdata, 32'd0);
    check("t4_w_ack", 32'(cpu_ack), 32'd1);
    check("t4_w_strobes", {30'd0, wr_en, rd_en}, 32'd0);
    cpu_req = 1'b0;
    step();
    check("t4_w_no_rvalid", 32'(cpu_rvalid), 32'd0);

    // Reset cancels a read in flight
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010;
    step();
    cpu_req = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_cancel_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rst_cancel_rdata", cpu_rdata, 32'd0);
    step();
    check("rst_cancel_late", 32'(cpu_rvalid), 32'd0);

    // Test 3: fill under continuous CPU reads (CPU granted first, same cycle as start)
    fill_start = 1'b1; fill_data = 32'h12345678;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h005;
    step();
    fill_start = 1'b0;
    writes = 0; bad = 0; busy_cnt = 0; done_cnt = 0; both_cnt = 0; alt_bad = 0;
    next_addr = '0;
    for (int j = 1; j <= 4615; j++) begin
      if (fill_busy) busy_cnt++;
      if (fill_done) done_cnt++;
      if (wr_en && rd_en) both_cnt++;
      if (j == 1) begin
        if (!(rd_en && !wr_en)) alt_bad++;
      end else if (j <= 4609) begin
        if (wr_en !== j[0] || rd_en !== !j[0]) alt_bad++;
      end
      if (wr_en) begin
        if (addr_a !== next_addr || data_in_a !== 32'h12345678) bad++;
        next_addr = next_addr + 12'd1;
        writes++;
      end
      step();
    end
    cpu_req = 1'b0;
    check("t3_writes", writes, 2304);
    check("t3_seq_bad", bad, 0);
    check("t3_busy_cycles", busy_cnt, 4608);
    check("t3_done_pulses", done_cnt, 1);
    check("t3_alternation", alt_bad, 0);
    check("t3_both", both_cnt, 0);
    repeat (3) step();

    // Test 5: second fill_start mid-fill is ignored
    fill_start = 1'b1; fill_data = 32'hAAAA5555;
    step();
    fill_start = 1'b0;
    writes = 0; bad = 0; busy_cnt = 0; done_cnt = 0;
    next_addr = '0; pulsed = 1'b0;
    for (int j = 1; j <= 2310; j++) begin
      if (fill_start) fill_start = 1'b0;
      if (fill_busy) busy_cnt++;
      if (fill_done) done_cnt++;
      if (wr_en) begin
        if (addr_a !== next_addr || data_in_a !== 32'hAAAA5555) bad++;
        if (addr_a == 12'd100 && !pulsed) begin
          fill_start = 1'b1;
          fill_data  = 32'h5555AAAA;
          pulsed     = 1'b1;
        end
        next_addr = next_addr + 12'd1;
        writes++;
      end
      step();
    end
    fill_start = 1'b0;
    check("t5_pulsed", 32'(pulsed), 32'd1);
    check("t5_writes", writes, 2304);
    check("t5_seq_bad", bad, 0);
    check("t5_busy_cycles", busy_cnt, 2304);
    check("t5_done_pulses", done_cnt, 1);
    repeat (2) step();

    // Test 6: reset aborts a fill at address 500
    fill_start = 1'b1; fill_data = 32'h33333333;
    step();
    fill_start = 1'b0;
    found = 1'b0;
    for (int j = 1; j <= 600; j++) begin
      if (wr_en && addr_a == 12'd500) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("t6_reached_500", 32'(found), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_busy", 32'(fill_busy), 32'd0);
    check("t6_wr_en", 32'(wr_en), 32'd0);
    check("t6_addr", 32'(addr_a), 32'd0);
    done_cnt = 0;
    for (int j = 0; j < 5; j++) begin
      if (fill_done || fill_busy || wr_en) done_cnt++;
      step();
    end
    check("t6_no_done", done_cnt, 0);
    check("t6_mem_kept", mem[500], 32'h33333333);
    check("t6_mem_unwritten", mem[501], 32'hAAAA5555);
    fill_start = 1'b1; fill_data = 32'h77777777;
    step();
    fill_start = 1'b0;
    check("t6_restart_busy", 32'(fill_busy), 32'd1);
    step();
    check("t6_restart_wr", 32'(wr_en), 32'd1);
    check("t6_restart_addr", 32'(addr_a), 32'd0);
    check("t6_restart_data", data_in_a, 32'h77777777);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
